// File: rtl/count_display_pkg.sv
// Shared types, widths and lookup tables for the count_display block.
package count_display_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned AN_W   = 4;
    localparam int unsigned SEG_W  = 7;

    // Counter modulus per mode, entry [0] is mode 00.
    localparam logic [3:0][CNT_W-1:0] MOD_TABLE = {4'd15, 4'd13, 4'd11, 4'd9};

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, entry [0] is digit 0.
    localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

    // Two-digit BCD increment with 99 -> 00 rollover.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] b);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = b[3:0];
        tens = b[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/count_display_if.sv
// Counter-to-display bus: counter value/mode in, tally and display drive out.
interface count_display_if;
    import count_display_pkg::*;

    logic [MODE_W-1:0] mode;
    logic [CNT_W-1:0]  count_in;
    logic              wrap_pulse;
    logic [BCD_W-1:0]  wrap_bcd;
    logic [AN_W-1:0]   an;
    logic [SEG_W-1:0]  seg;
    logic              err;

    modport master (
        output mode, count_in,
        input  wrap_pulse, wrap_bcd, an, seg, err
    );

    modport slave (
        input  mode, count_in,
        output wrap_pulse, wrap_bcd, an, seg, err
    );

endinterface

// File: rtl/seg7_encode.sv
// Combinational 4-bit value to active-low 7-segment pattern; non-decimal values blank.
module seg7_encode
    import count_display_pkg::*;
(
    input  logic [CNT_W-1:0] val,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (val < 4'd10) begin
            seg = SEG_TABLE[val];
        end
    end

endmodule

// File: rtl/count_display.sv
// Wrap detector, BCD wrap tally and 4-digit multiplexed 7-segment scanner.
// Optional sticky range error enabled by defining COUNT_RANGE_CHECK_EN.
module count_display
    import count_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input logic             clk,
    input logic             reset,
    count_display_if.slave  bus
);

    localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [MODE_W-1:0] mode_q;
    logic              pulse_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              wrap_c;
    logic              mode_chg_c;

    logic [PRE_W-1:0]  presc_q, presc_d;
    digit_t            idx_q, idx_d;
    logic [AN_W-1:0]   an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_c;
    logic [CNT_W-1:0]  digit_c;

    assign wrap_c     = (cnt_q != '0) && (bus.count_in == '0);
    assign mode_chg_c = (bus.mode != mode_q);

    // Input sampling, wrap detection and tally; a mode change clears the tally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            mode_q  <= '0;
            pulse_q <= 1'b0;
            bcd_q   <= '0;
        end else begin
            cnt_q   <= bus.count_in;
            mode_q  <= bus.mode;
            pulse_q <= wrap_c;
            if (mode_chg_c) begin
                bcd_q <= '0;
            end else if (wrap_c) begin
                bcd_q <= bcd_inc(bcd_q);
            end
        end
    end

`ifdef COUNT_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (mode_chg_c) begin
            err_q <= 1'b0;
        end else if (cnt_q >= MOD_TABLE[mode_q]) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Scan state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= DIG0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_c;
        end
    end

    // Next scan position and digit selection for the current index.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        an_d    = ~(AN_W'(1) << idx_q);
        digit_c = '0;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = digit_t'(idx_q + 2'd1);
        end
        unique case (idx_q)
            DIG0:    digit_c = (cnt_q >= 4'd10) ? cnt_q - 4'd10 : cnt_q;
            DIG1:    digit_c = {3'b000, (cnt_q >= 4'd10)};
            DIG2:    digit_c = bcd_q[3:0];
            DIG3:    digit_c = bcd_q[7:4];
            default: digit_c = '0;
        endcase
    end

    seg7_encode u_enc (
        .val (digit_c),
        .seg (seg_c)
    );

    assign bus.wrap_pulse = pulse_q;
    assign bus.wrap_bcd   = bcd_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: vector table, scoreboard model and scan/reset sequences.
module tb_count_display;
    import count_display_pkg::*;

`ifdef COUNT_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_display_if bus ();

    count_display #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       pulse;
        logic [7:0] bcd;
        logic       err;
    } sb_t;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] count;
        logic       pulse;
        logic [7:0] bcd;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] m_cnt;
    logic [1:0] m_mode;
    logic [7:0] m_bcd;
    logic       m_err;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] modulus(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd9;
            2'd1:    return 4'd11;
            2'd2:    return 4'd13;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [6:0] enc(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] tally_next(input logic [7:0] b);
        int v;
        v = (int'(b[7:4]) * 10 + int'(b[3:0]) + 1) % 100;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_cnt  = 4'd0;
        m_mode = 2'd0;
        m_bcd  = 8'h00;
        m_err  = 1'b0;
    endtask

    // Drive one cycle of inputs and queue the expected registered outputs.
    task automatic step(input logic [1:0] m, input logic [3:0] c);
        sb_t e;
        @(negedge clk);
        bus.mode     = m;
        bus.count_in = c;
        e.pulse = (m_cnt != 4'd0) && (c == 4'd0);
        if (m != m_mode) begin
            e.bcd = 8'h00;
            e.err = 1'b0;
        end else begin
            e.bcd = e.pulse ? tally_next(m_bcd) : m_bcd;
            e.err = m_err | (RANGE && (m_cnt >= modulus(m_mode)));
        end
        m_cnt  = c;
        m_mode = m;
        m_bcd  = e.bcd;
        m_err  = e.err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pulse", int'(bus.wrap_pulse), int'(e.pulse));
                chk("sb_bcd",   int'(bus.wrap_bcd),   int'(e.bcd));
                chk("sb_err",   int'(bus.err),        int'(e.err));
            end
        end
    end

    initial begin : main
        logic [3:0] an_exp[4];
        logic [6:0] seg_exp[4];
        logic [3:0] prev_an;
        bit         found;

        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_exp = '{enc(2), enc(1), enc(7), enc(3)};

        vecs[0] = '{2'd0, 4'd0, 1'b1, 8'h01};
        vecs[1] = '{2'd0, 4'd0, 1'b0, 8'h01};
        for (int i = 1; i <= 8; i++) vecs[1+i] = '{2'd0, 4'(i), 1'b0, 8'h01};
        vecs[10] = '{2'd0, 4'd0, 1'b1, 8'h02};
        vecs[11] = '{2'd0, 4'd3, 1'b0, 8'h02};
        vecs[12] = '{2'd0, 4'd0, 1'b1, 8'h03};

        // Reset with a live count on the bus.
        model_reset();
        reset        = 1'b0;
        bus.mode     = 2'd0;
        bus.count_in = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an",    int'(bus.an),         'hF);
        chk("rst_seg",   int'(bus.seg),        'h7F);
        chk("rst_bcd",   int'(bus.wrap_bcd),   0);
        chk("rst_pulse", int'(bus.wrap_pulse), 0);
        chk("rst_err",   int'(bus.err),        0);
        reset = 1'b1;

        step(2'd0, 4'd5);
        chk("scan_first_an",  int'(bus.an),  'hE);
        chk("scan_first_seg", int'(bus.seg), int'(enc(0)));
        repeat (3) step(2'd0, 4'd5);
        chk("scan_hold_an", int'(bus.an), 'hE);
        step(2'd0, 4'd5);
        chk("scan_adv_an",  int'(bus.an),  'hD);
        chk("scan_adv_seg", int'(bus.seg), int'(enc(0)));

        // Wrap detection vectors.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].mode, vecs[i].count);
            chk($sformatf("vec%0d_pulse", i), int'(bus.wrap_pulse), int'(vecs[i].pulse));
            chk($sformatf("vec%0d_bcd", i),   int'(bus.wrap_bcd),   int'(vecs[i].bcd));
        end

        // 100 full count cycles from a cleared tally.
        step(2'd1, 4'd0);
        step(2'd0, 4'd0);
        chk("clr_bcd", int'(bus.wrap_bcd), 0);
        for (int w = 1; w <= 100; w++) begin
            for (int c = 1; c <= 8; c++) step(2'd0, 4'(c));
            step(2'd0, 4'd0);
            if (w == 99) chk("wrap99_bcd", int'(bus.wrap_bcd), 'h99);
            if (w == 100) begin
                chk("wrap100_bcd",   int'(bus.wrap_bcd),   'h00);
                chk("wrap100_pulse", int'(bus.wrap_pulse), 1);
            end
        end

        // Mode change on the same edge as a wrap.
        step(2'd0, 4'd4); step(2'd0, 4'd0);
        step(2'd0, 4'd4); step(2'd0, 4'd0);
        step(2'd0, 4'd12); step(2'd0, 4'd12);
        chk("pre_chg_bcd", int'(bus.wrap_bcd), 'h02);
        chk("pre_chg_err", int'(bus.err), int'(RANGE));
        step(2'd2, 4'd0);
        chk("chg_pulse", int'(bus.wrap_pulse), 1);
        chk("chg_bcd",   int'(bus.wrap_bcd),   0);
        chk("chg_err",   int'(bus.err),        0);

        // Build tally 37, then hold count 12 and check one full scan.
        step(2'd3, 4'd0);
        repeat (37) begin
            step(2'd3, 4'd1);
            step(2'd3, 4'd0);
        end
        chk("tally37", int'(bus.wrap_bcd), 'h37);
        found   = 1'b0;
        prev_an = bus.an;
        for (int k = 0; k < 40; k++) begin
            step(2'd3, 4'd12);
            if (k > 0 && prev_an == 4'h7 && bus.an == 4'hE) begin
                found = 1'b1;
                break;
            end
            prev_an = bus.an;
        end
        chk("scan_align", int'(found), 1);
        if (found) begin
            for (int s = 0; s < 16; s++) begin
                if (s > 0) step(2'd3, 4'd12);
                chk($sformatf("scan%0d_an", s),  int'(bus.an),  int'(an_exp[s/4]));
                chk($sformatf("scan%0d_seg", s), int'(bus.seg), int'(seg_exp[s/4]));
            end
            step(2'd3, 4'd12);
            chk("scan_period_an", int'(bus.an), 'hE);
        end

        // Range error: sticky until mode change.
        step(2'd0, 4'd10);
        step(2'd0, 4'd10);
        chk("err_set", int'(bus.err), int'(RANGE));
        step(2'd0, 4'd3);
        step(2'd0, 4'd3);
        chk("err_sticky", int'(bus.err), int'(RANGE));
        step(2'd1, 4'd3);
        chk("err_clr", int'(bus.err), 0);
        step(2'd1, 4'd3);
        chk("err_stay_clr", int'(bus.err), 0);

        // Asynchronous reset mid-scan blanks at once; scan restarts at digit 0.
        repeat (5) step(2'd1, 4'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_an",  int'(bus.an),       'hF);
        chk("midrst_seg", int'(bus.seg),      'h7F);
        chk("midrst_bcd", int'(bus.wrap_bcd), 0);
        model_reset();
        reset = 1'b1;
        step(2'd1, 4'd3);
        chk("midrst_restart_an", int'(bus.an), 'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
